display_out_port: RTL and testbench

DISPLAY_OUT_PORT -- requirements
Module: display_out_port

---
 rtl/display_out_port.sv | 121 ++++++++++++
 tb/tb_display_out_port.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/display_out_port.sv
// display_out_port: host-to-terminal character port with da/rda_n handshake and a character queue.
// Define DSP_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module display_out_port #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic [7:1] rd,
    output logic       da,
    input  logic       rda_n,
    output logic [7:0] dsp_status,
    output logic       full,
    output logic       empty,
    output logic       overflow
);
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        $error("FIFO_DEPTH must be a power of two in 2..16");
    if (SYNC_STAGES < 2)
        $error("SYNC_STAGES must be at least 2");

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic rda_s, load, pop, push, ovf_set;
    logic [6:0] head;
    logic unused_bit7;

    assign unused_bit7 = wr_data[7];
    assign rda_s = sync[SYNC_STAGES-1];
    // A write into a full queue is still accepted when the head leaves in the same cycle.
    assign push = wr_en && (!full || pop);
    assign ovf_set = wr_en && full && !pop;
    assign dsp_status = {full, 7'b0};

    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], rda_n};
    end

    // Presenting is also gated on rda_s so da never rises while the terminal holds ack low.
    always_comb begin
        state_nx = state;
        load = 1'b0;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty && rda_s) begin
                load = 1'b1;
                state_nx = PRESENT;
            end
            PRESENT: if (!rda_s) begin
                pop = 1'b1;
                state_nx = RELEASE;
            end
            RELEASE: if (rda_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            da <= 1'b0;
            rd <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                da <= 1'b1;
                rd <= head;
            end else if (pop) begin
                da <= 1'b0;
            end
            overflow <= ovf_set | (overflow & ~clr_ovf);
        end
    end

`ifdef DSP_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [6:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data[6:0];
    end

    // The presented character stays in the queue until acknowledged, so it counts toward full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head = mem[rp];
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
`else
    logic [6:0] hold;
    logic occ;

    always_ff @(posedge clk) begin
        if (rst) occ <= 1'b0;
        else occ <= push | (occ & ~pop);
        if (push && !rst) hold <= wr_data[6:0];
    end

    assign head = hold;
    assign full = occ;
    assign empty = !occ;
`endif
endmodule

// File: tb/tb_display_out_port.sv
// tb_display_out_port: directed vectors for display_out_port; FIFO scenarios run when DSP_FIFO_EN is defined.
module tb_display_out_port;
    logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, clr_ovf = 1'b0, rda_n = 1'b1;
    logic [7:0] wr_data = '0;
    logic [7:1] rd;
    logic da, full, empty, overflow;
    logic [7:0] dsp_status;
    int n_vec = 0, n_bad = 0;
`ifdef DSP_FIFO_EN
    localparam int NQ = 4;
`else
    localparam int NQ = 1;
`endif

    display_out_port #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .rd(rd), .da(da), .rda_n(rda_n), .dsp_status(dsp_status),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic recv(input logic [6:0] exp);
        for (int k = 0; k < 20 && !da; k++) tick;
        chk("recv_da", da, 1);
        chk("recv_rd", rd, exp);
        rda_n = 1'b0;
        for (int k = 0; k < 20 && da; k++) tick;
        chk("recv_drop", da, 0);
        rda_n = 1'b1;
    endtask

    initial begin
        tick;
        tick;
        rst = 1'b0;
        chk("rst_da", da, 0);
        chk("rst_rd", rd, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_status", dsp_status, 0);

        wr(8'h8D);
        chk("wr_da_lat", da, 0);
        chk("wr_empty", empty, 0);
        tick;
        chk("pres_da", da, 1);
        chk("pres_rd", rd, 7'h0D);
        repeat (5) tick;
        chk("hold_da", da, 1);
        chk("hold_rd", rd, 7'h0D);

        rda_n = 1'b0;
        tick;
        chk("ack_s1_da", da, 1);
        tick;
        chk("ack_s2_da", da, 1);
        tick;
        chk("ack_da", da, 0);
        chk("ack_empty", empty, 1);

        wr(8'h52);
        repeat (3) tick;
        chk("rel_noda", da, 0);
        chk("rel_rdhold", rd, 7'h0D);
        rda_n = 1'b1;
        repeat (3) tick;
        chk("rel_wait_da", da, 0);
        tick;
        chk("rel_next_da", da, 1);
        chk("rel_next_rd", rd, 7'h52);
        rda_n = 1'b0;
        repeat (3) tick;
        chk("ack2_da", da, 0);
        rda_n = 1'b1;
        repeat (3) tick;
        chk("idle_empty", empty, 1);

`ifdef DSP_FIFO_EN
        for (int i = 0; i < 5; i++) begin
            wr(8'h41 + 8'(i));
            if (i == 3) begin
                chk("q_full4", full, 1);
                chk("q_noovf4", overflow, 0);
            end
        end
        chk("q_ovf5", overflow, 1);
        chk("q_status", dsp_status, 8'h80);
        for (int i = 0; i < 4; i++) recv(7'h41 + 7'(i));
        repeat (4) tick;
        chk("q_drain_empty", empty, 1);
        chk("q_drain_da", da, 0);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("q_clr", overflow, 0);

        for (int i = 0; i < 4; i++) wr(8'h61 + 8'(i));
        chk("q2_full", full, 1);
        chk("q2_rd", rd, 7'h61);
        rda_n = 1'b0;
        tick;
        tick;
        wr(8'h65);
        chk("q2_pop_full", full, 1);
        chk("q2_pop_ovf", overflow, 0);
        chk("q2_pop_da", da, 0);
        rda_n = 1'b1;
        for (int i = 0; i < 4; i++) recv(7'h62 + 7'(i));
        repeat (4) tick;
        chk("q2_empty", empty, 1);
`else
        wr(8'h41);
        wr(8'h42);
        chk("r_ovf", overflow, 1);
        chk("r_status", dsp_status, 8'h80);
        chk("r_full", full, 1);
        chk("r_rd", rd, 7'h41);
        clr_ovf = 1'b1;
        wr(8'h43);
        chk("r_setwins", overflow, 1);
        tick;
        clr_ovf = 1'b0;
        chk("r_clr", overflow, 0);
        chk("r_rd_keep", rd, 7'h41);
        rda_n = 1'b0;
        tick;
        tick;
        wr(8'h46);
        chk("r_pop_ovf", overflow, 0);
        chk("r_pop_full", full, 1);
        chk("r_pop_da", da, 0);
        rda_n = 1'b1;
        recv(7'h46);
        repeat (4) tick;
        chk("r_empty", empty, 1);
`endif

        for (int i = 0; i < NQ; i++) wr(8'h30 + 8'(i));
        for (int k = 0; k < 20 && !da; k++) tick;
        chk("mr_da", da, 1);
        rst = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h77;
        tick;
        chk("mr_da0", da, 0);
        chk("mr_empty", empty, 1);
        chk("mr_full", full, 0);
        tick;
        rst = 1'b0;
        wr_en = 1'b0;
        chk("mr_wr_ign", empty, 1);
        rda_n = 1'b0;
        repeat (4) tick;
        chk("mr_ack_da", da, 0);
        chk("mr_ack_empty", empty, 1);
        rda_n = 1'b1;
        repeat (4) tick;
        chk("mr_end_da", da, 0);
        chk("mr_end_rd", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
